// File: rtl/pipe_pkg.sv
// Shared types for pipeline-stage registers.
//   skid_state_t : occupancy state of the 2-entry skid stage
//   SKID_DEPTH   : number of storage entries (main + skid)
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with a 2-entry skid buffer and valid/ready handshake.
// Full throughput, 1-cycle latency, registered in_ready (no combinational
// ready path through the pipeline), flush for branch redirect.
// Ports:
//   clk, reset      : clock (rising edge), synchronous active-high reset
//   flush           : discard all held entries and any same-cycle in-transfer
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   count           : occupancy 0..2
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   count
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_ready_q;
  logic              in_xfer, out_xfer;
  logic              load_main, main_from_skid, load_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    case (state_q)
      ONE:     count = 2'd1;
      TWO:     count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: if (in_xfer) begin
        state_d   = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        // Skid entry moves up; it is never overtaken by new input
        // because in_ready is low in TWO.
        state_d        = ONE;
        load_main      = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including a same-cycle in-transfer.
    // Data registers simply keep their stale contents.
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      // Ready is a pure function of the next state, so it comes from a flop.
      in_ready_q <= (state_d != TWO);
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule
